// File: rtl/result_checker.sv
`default_nettype none
// ============================================================================
// Module   : result_checker
// Brief    : End-of-test monitor. Captures a DEPTH-word result window from
//            snooped memory writes and compares it with a preloaded golden
//            image once tohost is written or the run times out.
//            Optional per-byte strobe capture: RESULT_CHECKER_STRB_EN.
// Revision : 1.0
// ============================================================================
module result_checker #(
  parameter int              XLEN           = 32,
  parameter int              DEPTH          = 16,
  parameter logic [XLEN-1:0] DEBUG_BASE     = 32'h0000_F000,
  parameter logic [XLEN-1:0] TOHOST_ADDR    = 32'h0000_FFFC,
  parameter int              TIMEOUT_CYCLES = 1000,
  parameter int              IDXW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic                       start,
  input  logic                       gld_we,
  input  logic [IDXW-1:0]            gld_idx,
  input  logic [XLEN-1:0]            gld_data,
  input  logic                       wr_fire,
  input  logic [XLEN-1:0]            wr_addr,
  input  logic [XLEN-1:0]            wr_data,
  input  logic [XLEN/8-1:0]          wr_strb,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       timed_out,
  output logic [$clog2(DEPTH+1)-1:0] err_cnt,
  output logic [IDXW-1:0]            first_err_idx
);

  localparam int c_nb = XLEN / 8;
  localparam int c_ew = $clog2(DEPTH + 1);
  localparam int c_tw = $clog2(TIMEOUT_CYCLES + 1);
  localparam int c_aw = XLEN - 2;

  localparam logic [c_aw-1:0] c_base_word = DEBUG_BASE[XLEN-1:2];
  localparam logic [c_aw-1:0] c_depth     = c_aw'(DEPTH);
  localparam logic [c_tw-1:0] c_tmo_last  = c_tw'(TIMEOUT_CYCLES - 1);
  localparam logic [IDXW-1:0] c_idx_last  = IDXW'(DEPTH - 1);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_run   = 2'd1;
  localparam logic [1:0] c_st_check = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;

  logic [XLEN-1:0] r_gld [DEPTH];
  logic [XLEN-1:0] r_cap [DEPTH];
  logic [DEPTH-1:0] w_valid;

  logic [c_tw-1:0] r_timer;
  logic [IDXW-1:0] r_idx;
  logic [c_ew-1:0] r_err_cnt;
  logic [c_ew-1:0] w_err_nxt;
  logic [IDXW-1:0] r_first;
  logic            r_timed_out;
  logic            r_pass;

  logic [c_aw-1:0] w_off;
  logic [IDXW-1:0] w_widx;
  logic            w_in_win;
  logic            w_cap_we;
  logic            w_tohost;
  logic            w_timeout;
  logic            w_start_ok;
  logic            w_gld_ok;
  logic            w_mismatch;

  // Window hit: unsigned word offset from the base wraps large below it.
  assign w_off      = wr_addr[XLEN-1:2] - c_base_word;
  assign w_widx     = w_off[IDXW-1:0];
  assign w_in_win   = wr_fire && (w_off < c_depth);
  assign w_cap_we   = (r_state == c_st_run) && w_in_win;
  assign w_tohost   = wr_fire && (wr_addr == TOHOST_ADDR) && wr_data[0];
  assign w_timeout  = (r_timer == c_tmo_last);
  assign w_start_ok = start && ((r_state == c_st_idle) || (r_state == c_st_done));
  assign w_gld_ok   = gld_we && ((r_state == c_st_idle) || (r_state == c_st_done))
                      && (int'(gld_idx) < DEPTH);

  assign w_mismatch = !w_valid[r_idx] || (r_cap[r_idx] != r_gld[r_idx]);
  assign w_err_nxt  = r_err_cnt + c_ew'(w_mismatch);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (start) w_state_nxt = c_st_run;
      c_st_run:   if (w_tohost || w_timeout) w_state_nxt = c_st_check;
      c_st_check: if (r_idx == c_idx_last) w_state_nxt = c_st_done;
      c_st_done:  if (start) w_state_nxt = c_st_run;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      c_st_run, c_st_check: busy = 1'b1;
      c_st_done:            done = 1'b1;
      default:              ;
    endcase
  end

  assign pass          = r_pass;
  assign timed_out     = r_timed_out;
  assign err_cnt       = r_err_cnt;
  assign first_err_idx = r_first;

  // ---------------------------------------------------------------- control
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_timer     <= '0;
      r_idx       <= '0;
      r_err_cnt   <= '0;
      r_first     <= '0;
      r_timed_out <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle, c_st_done: begin
          if (w_start_ok) begin
            r_timer     <= '0;
            r_idx       <= '0;
            r_err_cnt   <= '0;
            r_first     <= '0;
            r_timed_out <= 1'b0;
            r_pass      <= 1'b0;
          end
        end
        c_st_run: begin
          r_timer <= r_timer + c_tw'(1);
          // A tohost write on the expiry cycle still counts as a clean finish.
          if (!w_tohost && w_timeout) begin
            r_timed_out <= 1'b1;
          end
        end
        c_st_check: begin
          r_idx     <= r_idx + IDXW'(1);
          r_err_cnt <= w_err_nxt;
          if (w_mismatch && (r_err_cnt == '0)) begin
            r_first <= r_idx;
          end
          if (r_idx == c_idx_last) begin
            r_pass <= (w_err_nxt == '0) && !r_timed_out;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- storage
  always_ff @(posedge ACLK) begin
    if (ARESETn && w_gld_ok) begin
      r_gld[gld_idx] <= gld_data;
    end
  end

`ifdef RESULT_CHECKER_STRB_EN
  logic [c_nb-1:0] r_seen [DEPTH];

  always_ff @(posedge ACLK) begin
    if (w_cap_we) begin
      for (int b = 0; b < c_nb; b++) begin
        if (wr_strb[b]) begin
          r_cap[w_widx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // An entry is valid only once every byte lane has been written this run.
  always_ff @(posedge ACLK) begin
    if (!ARESETn || w_start_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_seen[i] <= '0;
      end
    end else if (w_cap_we) begin
      r_seen[w_widx] <= r_seen[w_widx] | wr_strb;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_valid
    assign w_valid[g] = &r_seen[g];
  end
`else
  logic [DEPTH-1:0] r_valid;
  logic             w_unused_strb;

  assign w_unused_strb = ^wr_strb;

  always_ff @(posedge ACLK) begin
    if (w_cap_we) begin
      r_cap[w_widx] <= wr_data;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn || w_start_ok) begin
      r_valid <= '0;
    end else if (w_cap_we) begin
      r_valid[w_widx] <= 1'b1;
    end
  end

  assign w_valid = r_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_result_checker.sv
`default_nettype none
// Testbench for result_checker: expected end-of-test results are queued when
// the finishing stimulus is driven and compared when done rises.
module tb_result_checker;

  localparam int XLEN  = 32;
  localparam int DEPTH = 16;
  localparam int IDXW  = 4;
  localparam int EW    = $clog2(DEPTH + 1);
  localparam int TMO   = 1000;
  localparam logic [31:0] DBG    = 32'h0000_F000;
  localparam logic [31:0] TOHOST = 32'h0000_FFFC;

  logic            ACLK     = 1'b0;
  logic            ARESETn  = 1'b0;
  logic            start    = 1'b0;
  logic            gld_we   = 1'b0;
  logic [IDXW-1:0] gld_idx  = '0;
  logic [31:0]     gld_data = '0;
  logic            wr_fire  = 1'b0;
  logic [31:0]     wr_addr  = '0;
  logic [31:0]     wr_data  = '0;
  logic [3:0]      wr_strb  = '0;
  logic            busy, done, pass, timed_out;
  logic [EW-1:0]   err_cnt;
  logic [IDXW-1:0] first_err_idx;

  result_checker dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .start(start),
    .gld_we(gld_we), .gld_idx(gld_idx), .gld_data(gld_data),
    .wr_fire(wr_fire), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .busy(busy), .done(done), .pass(pass), .timed_out(timed_out),
    .err_cnt(err_cnt), .first_err_idx(first_err_idx)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic            timed;
    logic            pass;
    logic [EW-1:0]   err;
    logic [IDXW-1:0] first;
  } res_t;

  res_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] gold_m [DEPTH];
  logic [31:0] cap_m  [DEPTH];
  logic [3:0]  seen_m [DEPTH];
  bit          running = 1'b0;

  task automatic tick(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  task automatic load_golden(input int i, input logic [31:0] v, input bit accepted);
    gld_we = 1'b1; gld_idx = IDXW'(i); gld_data = v;
    @(negedge ACLK);
    gld_we = 1'b0;
    if (accepted) gold_m[i] = v;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    running = 1'b1;
    for (int i = 0; i < DEPTH; i++) seen_m[i] = 4'h0;
  endtask

  task automatic push_expected(input bit timed);
    res_t e;
    bit   found;
    e = '0; found = 1'b0; e.timed = timed;
    for (int i = 0; i < DEPTH; i++) begin
      if (seen_m[i] != 4'hF || cap_m[i] !== gold_m[i]) begin
        e.err = e.err + EW'(1);
        if (!found) e.first = IDXW'(i);
        found = 1'b1;
      end
    end
    e.pass = (e.err == '0) && !timed;
    exp_q.push_back(e);
    running = 1'b0;
  endtask

  task automatic drv_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int unsigned off;
    wr_fire = 1'b1; wr_addr = addr; wr_data = data; wr_strb = strb;
    @(negedge ACLK);
    wr_fire = 1'b0;
    if (running) begin
      off = (addr >> 2) - (DBG >> 2);
      if (off < DEPTH) begin
`ifdef RESULT_CHECKER_STRB_EN
        for (int b = 0; b < 4; b++) begin
          if (strb[b]) begin
            cap_m[off][b*8 +: 8] = data[b*8 +: 8];
            seen_m[off][b] = 1'b1;
          end
        end
`else
        cap_m[off]  = data;
        seen_m[off] = 4'hF;
`endif
      end
      if (addr == TOHOST && data[0]) push_expected(1'b0);
    end
  endtask

  task automatic write_all_matching();
    for (int i = 0; i < DEPTH; i++) drv_write(DBG + 32'(4 * i), gold_m[i], 4'hF);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge ACLK);
      cyc++;
    end
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    tick(2);
    n_checks++;
    if ({busy, done, pass, timed_out, err_cnt, first_err_idx} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b pass=%b to=%b err=%0d first=%0d, expected all 0",
               busy, done, pass, timed_out, err_cnt, first_err_idx);
    end
    ARESETn = 1'b1;
    tick(1);
  endtask

  task automatic test_pass();
    int   cyc;
    res_t e;
    for (int i = 0; i < DEPTH; i++) load_golden(i, 32'(i + 1), 1'b1);
    do_start();
    n_checks++;
    if ({busy, done} !== 2'b10) begin
      n_fail++;
      $display("FAIL start_busy: got busy=%b done=%b, expected busy=1 done=0", busy, done);
    end
    write_all_matching();
    drv_write(TOHOST, 32'h1, 4'hF);
    wait_done(cyc);
    n_checks++;
    if (cyc != DEPTH) begin
      n_fail++;
      $display("FAIL pass_latency: got %0d cycles, expected %0d", cyc, DEPTH);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    n_checks++;
    if ({timed_out, pass, err_cnt, first_err_idx} !== e) begin
      n_fail++;
      $display("FAIL pass_result: got to=%b pass=%b err=%0d first=%0d, expected to=%b pass=%b err=%0d first=%0d",
               timed_out, pass, err_cnt, first_err_idx, e.timed, e.pass, e.err, e.first);
    end
    // Writes in DONE, including tohost, must not disturb the held result.
    drv_write(DBG, 32'hBAD0_BAD0, 4'hF);
    drv_write(TOHOST, 32'h1, 4'hF);
    tick(3);
    n_checks++;
    if ({done, timed_out, pass, err_cnt, first_err_idx} !== {1'b1, e}) begin
      n_fail++;
      $display("FAIL done_hold: got done=%b pass=%b err=%0d first=%0d, expected done=1 pass=%b err=%0d first=%0d",
               done, pass, err_cnt, first_err_idx, e.pass, e.err, e.first);
    end
  endtask

  task automatic test_errors();
    int   cyc;
    res_t e;
    for (int i = 0; i < DEPTH; i++) load_golden(i, 32'(i + 1), 1'b1);
    do_start();
    drv_write(DBG + 32'd8, 32'h1234_5678, 4'hF);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 9) continue;
      if (i == 5) drv_write(DBG + 32'd20, 32'h0000_DEAD, 4'hF);
      else if (i == 3) drv_write(DBG + 32'd14, gold_m[i], 4'hF);
      else drv_write(DBG + 32'(4 * i), gold_m[i], 4'hF);
    end
    drv_write(DBG - 32'd4, 32'hFFFF_FFFF, 4'hF);
    drv_write(DBG + 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'hF);
    load_golden(5, 32'h0000_DEAD, 1'b0);
    start = 1'b1; tick(1); start = 1'b0;
    drv_write(TOHOST, 32'h2, 4'hF);
    tick(2);
    n_checks++;
    if ({busy, done} !== 2'b10) begin
      n_fail++;
      $display("FAIL tohost_bit0_clear: got busy=%b done=%b, expected busy=1 done=0", busy, done);
    end
    drv_write(TOHOST, 32'h1, 4'hF);
    wait_done(cyc);
    n_checks++;
    if (cyc != DEPTH) begin
      n_fail++;
      $display("FAIL errors_latency: got %0d cycles, expected %0d", cyc, DEPTH);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    n_checks++;
    if ({timed_out, pass, err_cnt, first_err_idx} !== e) begin
      n_fail++;
      $display("FAIL errors_result: got to=%b pass=%b err=%0d first=%0d, expected to=%b pass=%b err=%0d first=%0d",
               timed_out, pass, err_cnt, first_err_idx, e.timed, e.pass, e.err, e.first);
    end
  endtask

  task automatic test_timeout();
    int   cyc;
    res_t e;
    for (int i = 0; i < DEPTH; i++) load_golden(i, 32'(i + 1), 1'b1);
    do_start();
    write_all_matching();
    push_expected(1'b1);
    wait_done(cyc);
    n_checks++;
    if (cyc + DEPTH != TMO + DEPTH) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d cycles from RUN entry to done, expected %0d",
               cyc + DEPTH, TMO + DEPTH);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    n_checks++;
    if ({timed_out, pass, err_cnt, first_err_idx} !== e) begin
      n_fail++;
      $display("FAIL timeout_result: got to=%b pass=%b err=%0d first=%0d, expected to=%b pass=%b err=%0d first=%0d",
               timed_out, pass, err_cnt, first_err_idx, e.timed, e.pass, e.err, e.first);
    end
  endtask

  task automatic test_tohost_at_timeout();
    int   cyc;
    res_t e;
    do_start();
    write_all_matching();
    tick(TMO - 1 - DEPTH);
    drv_write(TOHOST, 32'h1, 4'hF);
    wait_done(cyc);
    n_checks++;
    if (cyc != DEPTH) begin
      n_fail++;
      $display("FAIL race_latency: got %0d cycles, expected %0d", cyc, DEPTH);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    n_checks++;
    if ({timed_out, pass, err_cnt, first_err_idx} !== e) begin
      n_fail++;
      $display("FAIL race_result: got to=%b pass=%b err=%0d first=%0d, expected to=%b pass=%b err=%0d first=%0d",
               timed_out, pass, err_cnt, first_err_idx, e.timed, e.pass, e.err, e.first);
    end
  endtask

  task automatic test_strobes();
    int   cyc;
    res_t e;
    for (int run = 0; run < 2; run++) begin
      do_start();
      for (int i = 1; i < DEPTH; i++) drv_write(DBG + 32'(4 * i), gold_m[i], 4'hF);
      if (run == 0) begin
`ifdef RESULT_CHECKER_STRB_EN
        drv_write(DBG, 32'hABCD_0001, 4'b0011);
        drv_write(DBG, 32'h0000_FFFF, 4'b1100);
`else
        drv_write(DBG, 32'h0000_0001, 4'b0000);
`endif
      end else begin
        drv_write(DBG, 32'hFFFF_0001, 4'b0011);
      end
      drv_write(TOHOST, 32'h1, 4'hF);
      wait_done(cyc);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      n_checks++;
      if ({timed_out, pass, err_cnt, first_err_idx} !== e) begin
        n_fail++;
        $display("FAIL strobe_run%0d: got to=%b pass=%b err=%0d first=%0d, expected to=%b pass=%b err=%0d first=%0d",
                 run, timed_out, pass, err_cnt, first_err_idx, e.timed, e.pass, e.err, e.first);
      end
    end
  endtask

  task automatic test_reset_mid_check();
    int   cyc;
    res_t e;
    do_start();
    for (int i = 0; i < DEPTH - 1; i++) drv_write(DBG + 32'(4 * i), 32'hFFFF_FFFF, 4'hF);
    drv_write(TOHOST, 32'h1, 4'hF);
    exp_q.delete();
    tick(5);
    ARESETn = 1'b0;
    tick(1);
    n_checks++;
    if ({busy, done, pass, timed_out, err_cnt, first_err_idx} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_check: got busy=%b done=%b pass=%b to=%b err=%0d first=%0d, expected all 0",
               busy, done, pass, timed_out, err_cnt, first_err_idx);
    end
    ARESETn = 1'b1;
    running = 1'b0;
    tick(1);
    for (int i = 0; i < DEPTH; i++) load_golden(i, 32'(i * 5 + 3), 1'b1);
    do_start();
    write_all_matching();
    drv_write(TOHOST, 32'h1, 4'hF);
    wait_done(cyc);
    n_checks++;
    if (cyc != DEPTH) begin
      n_fail++;
      $display("FAIL rerun_latency: got %0d cycles, expected %0d", cyc, DEPTH);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    n_checks++;
    if ({timed_out, pass, err_cnt, first_err_idx} !== e) begin
      n_fail++;
      $display("FAIL rerun_result: got to=%b pass=%b err=%0d first=%0d, expected to=%b pass=%b err=%0d first=%0d",
               timed_out, pass, err_cnt, first_err_idx, e.timed, e.pass, e.err, e.first);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_errors();
    test_timeout();
    test_tohost_at_timeout();
    test_strobes();
    test_reset_mid_check();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/result_checker.md
# result_checker

Synthesizable end-of-test checker for the AXI CPU system: snoops data-memory writes, captures a result window of DEPTH words starting at DEBUG_BASE, and compares it against a preloaded golden image. Detects completion via a tohost write or a cycle timeout, then produces pass/fail, error count and first-mismatch index. Sits beside the memory slave in `top_axi`, replacing end-of-simulation file comparison with a cycle-accurate, FPGA-usable monitor.

## Interface
- XLEN, 32, data/address width
- DEPTH, 16, golden/capture entries (words), ≥1
- DEBUG_BASE, 32'h0000_F000, byte address of result window (word aligned)
- TOHOST_ADDR, 32'h0000_FFFC, byte address whose write ends the test
- TIMEOUT_CYCLES, 1000, RUN cycles before timeout, ≥1
- IDXW, $clog2(DEPTH) (min 1), index width

- ACLK  in  1  clock
- ARESETn  in  1  reset; synchronous, active-low
- start  in  1  pulse: begin RUN (accepted in IDLE or DONE)
- gld_we  in  1  golden write strobe
- gld_idx  in  IDXW  golden entry index
- gld_data  in  XLEN  golden value
- wr_fire  in  1  a write handshake completed this cycle (AW+W accepted)
- wr_addr  in  XLEN  write byte address
- wr_data  in  XLEN  write data
- wr_strb  in  XLEN/8  byte strobes
- busy  out  1  state is RUN or CHECK
- done  out  1  state is DONE
- pass  out  1  valid when done; 1 = no errors and no timeout
- timed_out  out  1  test ended by timeout
- err_cnt  out  $clog2(DEPTH+1)  mismatching entries
- first_err_idx  out  IDXW  lowest mismatching index (0 if none)

## Operation
- States: IDLE → RUN → CHECK → DONE; DONE → RUN on start.
- IDLE: gld_we writes golden[gld_idx]; wr_fire ignored. start → RUN; capture valid bits, timer, err_cnt, first_err_idx, timed_out cleared on RUN entry.
- RUN: wr_fire with wr_addr[XLEN-1:2] in [DEBUG_BASE>>2, (DEBUG_BASE>>2)+DEPTH) writes capture[idx], idx = (wr_addr−DEBUG_BASE)>>2; sets valid[idx]; wr_addr[1:0] ignored. Later writes to same idx overwrite.
- RUN exit: wr_fire to TOHOST_ADDR with wr_data[0]=1 → CHECK; otherwise timer reaching TIMEOUT_CYCLES → CHECK with timed_out=1. Both same cycle: tohost wins, timed_out=0. TOHOST_ADDR inside window: capture also happens.
- CHECK: scans idx 0..DEPTH−1, one entry per cycle; mismatch if !valid[idx] or capture≠golden. err_cnt increments per mismatch; first_err_idx latched on first. After idx DEPTH−1 → DONE.
- DONE: outputs held; gld_we accepted (reload for next run); wr_fire ignored.
- gld_we in RUN/CHECK ignored. start outside IDLE/DONE ignored.
- Golden contents undefined after reset until loaded; not cleared by reset or start.

## Timing
- Reset (ARESETn=0 at a posedge): state IDLE, busy=0, done=0, pass=0, timed_out=0, err_cnt=0, first_err_idx=0, all valid bits 0. Reset mid-RUN/CHECK aborts immediately, no result.
- start sampled at posedge N → busy=1 from N+1.
- Timer counts each RUN cycle starting at 0 on entry; timeout after exactly TIMEOUT_CYCLES RUN cycles with no tohost.
- Capture write visible to CHECK one cycle after wr_fire.
- Tohost at posedge N → CHECK at N+1 → done=1 at N+1+DEPTH; pass/err_cnt/first_err_idx stable when done rises.
- pass = done & (err_cnt==0) & !timed_out, registered.

## Configuration
- RESULT_CHECKER_STRB_EN defined: capture applies wr_strb per byte; valid[idx] set only when all four strobes have been seen since RUN entry (tracked per byte).
- Undefined: wr_strb ignored; every in-window wr_fire writes the full word and sets valid[idx].

## Test plan
- Load golden[i]=i+1 (DEPTH=16), start, write all 16 matching words, tohost write 1 → done after 16 CHECK cycles, pass=1, err_cnt=0.
- Same, but entry 5 written 0xDEAD and entry 9 never written → pass=0, err_cnt=2, first_err_idx=5.
- No tohost write, TIMEOUT_CYCLES=1000 → CHECK entered exactly 1000 cycles after RUN entry, timed_out=1, pass=0 even with all entries matching.
- Tohost write on the same cycle the timer expires → timed_out=0, pass=1 for matching data.
- With RESULT_CHECKER_STRB_EN: entry 0 written strb=4'b0011 then 4'b1100 → valid, value merged; only 4'b0011 → counted as mismatch. Writes outside window or tohost with wr_data[0]=0 → no effect.
- Assert ARESETn=0 mid-CHECK → all outputs reset next cycle; start after reload rerun passes.
